// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundle between the ID stage / pipeline control and the hazard controller.
//   master : ID-stage side, drives decoded source/destination info and
//            receives forwarding selects and hold/stall/bubble/flush controls.
//   slave  : hazard controller side.
//   Signals:
//     id_valid, id_rs_idx, id_rm_idx, id_uses_rs, id_uses_rm, id_uses_t,
//     id_dst_idx, id_is_load, branch_taken, mem_ram_access  (ID -> ctrl)
//     fwd_rs_sel, fwd_rm_sel, fwd_t_sel, pc_hold, stall_id, if_bubble,
//     flush_if                                              (ctrl -> ID)
// ---------------------------------------------------------------------------
interface hazard_ctrl_if;
  logic       id_valid;
  logic [3:0] id_rs_idx;
  logic [3:0] id_rm_idx;
  logic       id_uses_rs;
  logic       id_uses_rm;
  logic       id_uses_t;
  logic [3:0] id_dst_idx;
  logic       id_is_load;
  logic       branch_taken;
  logic       mem_ram_access;

  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rm_sel;
  logic [1:0] fwd_t_sel;
  logic       pc_hold;
  logic       stall_id;
  logic       if_bubble;
  logic       flush_if;

  modport master (
    output id_valid, id_rs_idx, id_rm_idx, id_uses_rs, id_uses_rm, id_uses_t,
           id_dst_idx, id_is_load, branch_taken, mem_ram_access,
    input  fwd_rs_sel, fwd_rm_sel, fwd_t_sel, pc_hold, stall_id, if_bubble,
           flush_if
  );

  modport slave (
    input  id_valid, id_rs_idx, id_rm_idx, id_uses_rs, id_uses_rm, id_uses_t,
           id_dst_idx, id_is_load, branch_taken, mem_ram_access,
    output fwd_rs_sel, fwd_rm_sel, fwd_t_sel, pc_hold, stall_id, if_bubble,
           flush_if
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Hazard controller for the 16-bit five-stage core (IF/ID/EX/MEM/WB).
//   Tracks destination tags of the instructions in EX, MEM and WB, derives
//   operand and T-flag forwarding selects for the ALU inputs, inserts a
//   load-use bubble into EX, and holds PC/IF while MEM borrows the shared RAM.
//
//   Ports:
//     clk            core clock, rising edge
//     rst            synchronous reset, active-high
//     hz (slave)     ID-side bundle, see hazard_ctrl_if
//   Optional (macro HAZARD_PERF_EN):
//     perf_stall_cnt saturating count of cycles with pc_hold=1
//     perf_lu_cnt    saturating count of load-use stall entries
//
//   Forward select encoding: 0 regfile, 1 EX, 2 MEM, 3 WB result.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned MEM_WAIT_CYCLES = 1,
  parameter logic [3:0]  NONE_IDX        = 4'd15
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]  perf_stall_cnt,
  output logic [15:0]  perf_lu_cnt
`endif
);

  localparam logic [3:0] T_IDX      = 4'd11;
  localparam logic [3:0] WAIT_RELOAD = 4'(MEM_WAIT_CYCLES - 1);

  typedef struct packed {
    logic       vld;
    logic [3:0] idx;
    logic       ld;
  } tag_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_STALL = 2'd1,
    SM_WAIT  = 2'd2
  } state_t;

  tag_t   ex_tag_q, mem_tag_q, wb_tag_q;
  tag_t   ex_tag_d;
  state_t state_q;
  logic [3:0] cnt_q;

  logic lu;
  logic stall;
  logic hold;

  function automatic logic tag_hit(input tag_t t, input logic [3:0] idx);
    return t.vld && (t.idx == idx) && (idx != NONE_IDX);
  endfunction

  // Youngest producer wins; a load still in EX cannot forward yet, so the
  // search falls through to older stages (the load-use stall covers it).
  function automatic logic [1:0] fwd_sel(input logic used, input logic [3:0] idx,
                                         input tag_t ex, input tag_t mem,
                                         input tag_t wb);
    logic [1:0] sel;
    sel = 2'd0;
    if (used && idx != NONE_IDX) begin
      if (tag_hit(ex, idx) && !ex.ld) sel = 2'd1;
      else if (tag_hit(mem, idx))     sel = 2'd2;
      else if (tag_hit(wb, idx))      sel = 2'd3;
    end
    return sel;
  endfunction

  always_comb begin
    lu = hz.id_valid && ex_tag_q.vld && ex_tag_q.ld &&
         ((hz.id_uses_rs && tag_hit(ex_tag_q, hz.id_rs_idx)) ||
          (hz.id_uses_rm && tag_hit(ex_tag_q, hz.id_rm_idx)) ||
          (hz.id_uses_t  && tag_hit(ex_tag_q, T_IDX)));
  end

  assign stall = !rst && lu;
  assign hold  = !rst && (lu || state_q == SM_WAIT);

  assign hz.stall_id   = stall;
  assign hz.pc_hold    = hold;
  assign hz.if_bubble  = !rst && (state_q == SM_WAIT) && !lu;
  // A branch that needs a stalled load is re-resolved once the stall clears.
  assign hz.flush_if   = !rst && hz.branch_taken && !lu;

  assign hz.fwd_rs_sel = (rst || !hz.id_valid) ? 2'd0 :
                         fwd_sel(hz.id_uses_rs, hz.id_rs_idx, ex_tag_q, mem_tag_q, wb_tag_q);
  assign hz.fwd_rm_sel = (rst || !hz.id_valid) ? 2'd0 :
                         fwd_sel(hz.id_uses_rm, hz.id_rm_idx, ex_tag_q, mem_tag_q, wb_tag_q);
  assign hz.fwd_t_sel  = (rst || !hz.id_valid) ? 2'd0 :
                         fwd_sel(hz.id_uses_t, T_IDX, ex_tag_q, mem_tag_q, wb_tag_q);

  always_comb begin
    ex_tag_d = '0;
    if (hz.id_valid && !lu && hz.id_dst_idx != NONE_IDX) begin
      ex_tag_d.vld = 1'b1;
      ex_tag_d.idx = hz.id_dst_idx;
      ex_tag_d.ld  = hz.id_is_load;
    end
  end

  // Tag pipeline: ID -> EX -> MEM -> WB
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_tag_q  <= '0;
      mem_tag_q <= '0;
      wb_tag_q  <= '0;
    end else begin
      ex_tag_q  <= ex_tag_d;
      mem_tag_q <= ex_tag_q;
      wb_tag_q  <= mem_tag_q;
    end
  end

  // Hazard FSM: LU_STALL marks the cycle after a load-use bubble; SM_WAIT
  // holds fetch while MEM owns the shared RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lu) begin
            state_q <= LU_STALL;
          end else if (hz.mem_ram_access) begin
            state_q <= SM_WAIT;
            cnt_q   <= WAIT_RELOAD;
          end
        end
        LU_STALL: begin
          if (hz.mem_ram_access) begin
            state_q <= SM_WAIT;
            cnt_q   <= WAIT_RELOAD;
          end else begin
            state_q <= IDLE;
          end
        end
        SM_WAIT: begin
          if (hz.mem_ram_access) begin
            cnt_q <= WAIT_RELOAD;
          end else if (cnt_q == 4'd0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= 16'd0;
      perf_lu_cnt    <= 16'd0;
    end else begin
      if (hold && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (state_q == IDLE && lu && perf_lu_cnt != 16'hFFFF)
        perf_lu_cnt <= perf_lu_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam logic [3:0] N = 4'd15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_EN
  logic [15:0] perf_stall_cnt, perf_lu_cnt;
`endif

  hazard_ctrl #(.MEM_WAIT_CYCLES(3), .NONE_IDX(4'd15)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_lu_cnt    (perf_lu_cnt)
`endif
  );

  typedef struct {
    logic       rst, vld;
    logic [3:0] rs;  logic urs;
    logic [3:0] rm;  logic urm;
    logic       ut;
    logic [3:0] dst;
    logic       ld, br, mra;
    logic [9:0] exp; // {frs, frm, ft, pc_hold, stall_id, if_bubble, flush_if}
  } vec_t;

  vec_t tv[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(
    input logic r, input logic v, input logic [3:0] rs, input logic urs,
    input logic [3:0] rm, input logic urm, input logic ut, input logic [3:0] dst,
    input logic ld, input logic br, input logic mra,
    input logic [1:0] frs, input logic [1:0] frm, input logic [1:0] ft,
    input logic ph, input logic st, input logic bb, input logic fl);
    vec_t x;
    x.rst = r; x.vld = v; x.rs = rs; x.urs = urs; x.rm = rm; x.urm = urm;
    x.ut = ut; x.dst = dst; x.ld = ld; x.br = br; x.mra = mra;
    x.exp = {frs, frm, ft, ph, st, bb, fl};
    return x;
  endfunction

  task automatic drive(input vec_t v);
    rst               = v.rst;
    hz.id_valid       = v.vld;
    hz.id_rs_idx      = v.rs;
    hz.id_uses_rs     = v.urs;
    hz.id_rm_idx      = v.rm;
    hz.id_uses_rm     = v.urm;
    hz.id_uses_t      = v.ut;
    hz.id_dst_idx     = v.dst;
    hz.id_is_load     = v.ld;
    hz.branch_taken   = v.br;
    hz.mem_ram_access = v.mra;
  endtask

  // One cycle: drive just after the rising edge, sample mid-cycle.
  task automatic step(input vec_t v, input string name);
    logic [9:0] act;
    @(posedge clk);
    #1;
    drive(v);
    #3;
    act = {hz.fwd_rs_sel, hz.fwd_rm_sel, hz.fwd_t_sel,
           hz.pc_hold, hz.stall_id, hz.if_bubble, hz.flush_if};
    n_checks++;
    if (act !== v.exp) begin
      n_fail++;
      $display("FAIL %s: got frs=%0d frm=%0d ft=%0d hold=%b stall=%b bub=%b flush=%b, expected frs=%0d frm=%0d ft=%0d hold=%b stall=%b bub=%b flush=%b",
               name, act[9:8], act[7:6], act[5:4], act[3], act[2], act[1], act[0],
               v.exp[9:8], v.exp[7:6], v.exp[5:4], v.exp[3], v.exp[2], v.exp[1], v.exp[0]);
    end
  endtask

  initial begin
    //                rst vld rs urs rm urm ut dst ld br mra | frs frm ft ph st bb fl
    tv.push_back(mk(1, 1, N, 0, N, 0, 0, N, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0)); // 0 reset outputs
    tv.push_back(mk(0, 0, N, 0, N, 0, 0, N, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // 1 idle after reset
    tv.push_back(mk(0, 1, N, 0, N, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // 2 addu r1
    tv.push_back(mk(0, 1, 1, 1, 2, 1, 0, 3, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0)); // 3 reads r1 -> EX
    tv.push_back(mk(0, 1, 3, 1, 1, 1, 0, N, 0, 0, 0,  1, 2, 0, 0, 0, 0, 0)); // 4 r3 EX, r1 MEM
    tv.push_back(mk(0, 1, 1, 1, 3, 1, 0, N, 0, 0, 0,  3, 2, 0, 0, 0, 0, 0)); // 5 r1 WB, r3 MEM
    tv.push_back(mk(0, 1, 3, 0, 3, 1, 0, N, 0, 0, 0,  0, 3, 0, 0, 0, 0, 0)); // 6 unused source
    tv.push_back(mk(0, 1, N, 0, N, 0, 0, 4, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // 7 r4
    tv.push_back(mk(0, 1, N, 0, N, 0, 0, 4, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // 8 r4 again
    tv.push_back(mk(0, 1, 4, 1, N, 0, 0, N, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0)); // 9 youngest wins
    tv.push_back(mk(0, 0, 4, 1, N, 0, 0, N, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // 10 id_valid=0
    tv.push_back(mk(0, 1, 4, 1, N, 0, 0, N, 0, 0, 0,  3, 0, 0, 0, 0, 0, 0)); // 11 r4 in WB
    tv.push_back(mk(0, 1, N, 0, N, 0, 0, 2, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // 12 lw r2
    tv.push_back(mk(0, 1, N, 0, 2, 1, 0, 5, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0)); // 13 load-use stall
    tv.push_back(mk(0, 1, N, 0, 2, 1, 0, 5, 0, 0, 0,  0, 2, 0, 0, 0, 0, 0)); // 14 r2 from MEM
    tv.push_back(mk(0, 1, N, 0, N, 0, 0, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // 15 slt
    tv.push_back(mk(0, 1, N, 0, N, 0, 1, N, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0)); // 16 bteqz T EX
    tv.push_back(mk(0, 1, N, 0, N, 0, 0, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // 17 slt
    tv.push_back(mk(0, 0, N, 0, N, 0, 1, N, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // 18 nop
    tv.push_back(mk(0, 1, N, 0, N, 0, 1, N, 0, 0, 0,  0, 0, 2, 0, 0, 0, 0)); // 19 bteqz T MEM
    tv.push_back(mk(0, 1, N, 0, N, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // 20 lw r3
    tv.push_back(mk(0, 1, 3, 1, N, 0, 0, N, 0, 1, 0,  0, 0, 0, 1, 1, 0, 0)); // 21 branch waits
    tv.push_back(mk(0, 1, 3, 1, N, 0, 0, N, 0, 1, 0,  2, 0, 0, 0, 0, 0, 1)); // 22 branch flushes
    tv.push_back(mk(0, 0, N, 0, N, 0, 0, N, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0)); // 23 RAM pulse
    tv.push_back(mk(0, 0, N, 0, N, 0, 0, N, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0)); // 24 wait 1
    tv.push_back(mk(0, 0, N, 0, N, 0, 0, N, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0)); // 25 wait 2
    tv.push_back(mk(0, 0, N, 0, N, 0, 0, N, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0)); // 26 wait 3
    tv.push_back(mk(0, 0, N, 0, N, 0, 0, N, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // 27 back to idle
    tv.push_back(mk(0, 1, N, 0, N, 0, 0, 6, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0)); // 28 lw r6 + RAM
    tv.push_back(mk(0, 1, 6, 1, N, 0, 0, N, 0, 1, 0,  0, 0, 0, 1, 1, 0, 0)); // 29 lu during wait
    tv.push_back(mk(0, 1, 6, 1, N, 0, 0, N, 0, 1, 0,  2, 0, 0, 1, 0, 1, 1)); // 30 wait, flush
    tv.push_back(mk(0, 0, N, 0, N, 0, 0, N, 0, 0, 1,  0, 0, 0, 1, 0, 1, 0)); // 31 reload at cnt 0
    tv.push_back(mk(0, 0, N, 0, N, 0, 0, N, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0)); // 32
    tv.push_back(mk(0, 0, N, 0, N, 0, 0, N, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0)); // 33
    tv.push_back(mk(0, 0, N, 0, N, 0, 0, N, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0)); // 34
    tv.push_back(mk(0, 0, N, 0, N, 0, 0, N, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // 35 idle

    drive(mk(1, 0, N, 0, N, 0, 0, N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tv[i]) step(tv[i], $sformatf("row%0d", i));

    // Reset in the middle of SM_WAIT (cnt=2) with a tag in flight.
    step(mk(0, 1, N, 0, N, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "rst_seq_pulse");
    step(mk(1, 1, 7, 1, N, 0, 1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "rst_seq_during");
    step(mk(0, 1, 7, 1, 7, 1, 0, N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_seq_after");
    step(mk(0, 1, 7, 1, 7, 1, 1, N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_seq_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 100000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 16-bit five-stage core (IF, ID, EX, MEM, WB). It sequences the ALU datapath.
- Tracks destination tags of in-flight instructions and drives operand/T-flag forwarding selects for the ALU inputs.
- Inserts load-use bubbles (nop 0x0800) into EX and holds PC/IF when the MEM stage steals the shared RAM from fetch.
- Sits beside the ID/EX pipeline register; the register file, forwarding muxes and PC register consume its outputs.

Parameters:
- MEM_WAIT_CYCLES, 1, fetch-hold cycles per MEM-stage RAM access (1..15).
- NONE_IDX, 15, register index meaning "no register"; never matches any tag.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- id_valid  input  1  ID holds a real instruction.
- id_rs_idx  input  4  ID source A index: 0-7 GPR, 8 SP, 9 IH, 10 RA, 11 T.
- id_rm_idx  input  4  ID source B index, same encoding.
- id_uses_rs, id_uses_rm, id_uses_t  input  1 each  source actually read.
- id_dst_idx  input  4  ID destination index (NONE_IDX if none).
- id_is_load  input  1  ID instruction is lw/lw_sp.
- branch_taken  input  1  ID resolved a taken branch/jump this cycle.
- mem_ram_access  input  1  instruction now entering MEM uses the shared RAM.
- fwd_rs_sel, fwd_rm_sel, fwd_t_sel  output  2 each  0 regfile, 1 EX result, 2 MEM result, 3 WB result.
- pc_hold  output  1  PC and IF/ID register hold.
- stall_id  output  1  ID/EX register loads nop and ID is held.
- if_bubble  output  1  IF/ID loads nop 0x0800 instead of the fetched word.
- flush_if  output  1  kill the instruction in IF.

Behaviour:
Tag pipeline:
- Three registered tags: ex_tag, mem_tag, wb_tag. Each tag is {valid, idx[3:0], is_load}.
- Every cycle: wb_tag<=mem_tag and mem_tag<=ex_tag.
- ex_tag <= {1, id_dst_idx, id_is_load} when id_valid && !stall_id && id_dst_idx!=NONE_IDX. Otherwise ex_tag <= invalid.

Forwarding (combinational from tags and ID inputs):
- The select for a source is 1 if ex_tag matches it and ex_tag is not a load.
- Otherwise 2 if mem_tag matches, otherwise 3 if wb_tag matches, otherwise 0. The youngest match wins.
- A source that is unused, or has idx NONE_IDX, gets select 0.
- fwd_t_sel is computed the same way against idx 11.

Load-use hazard:
- lu = id_valid && ex_tag.valid && ex_tag.is_load && a used source matches ex_tag.idx.
- When lu is true: stall_id=1 and pc_hold=1.
- The next cycle the load is in MEM and forwarding selects 2; no second stall.

FSM states IDLE, LU_STALL, SM_WAIT (registered), 4-bit counter cnt:
- IDLE: lu -> LU_STALL. Else if mem_ram_access -> SM_WAIT with cnt=MEM_WAIT_CYCLES-1.
- LU_STALL: one cycle, then IDLE, or SM_WAIT if mem_ram_access is high.
- SM_WAIT: pc_hold=1, if_bubble=!stall_id. When cnt==0 -> IDLE, else cnt decrements.
- A new mem_ram_access while in SM_WAIT reloads cnt to MEM_WAIT_CYCLES-1.
- While in SM_WAIT, lu can still assert stall_id combinationally in the same cycle.

Priorities and boundary cases:
- flush_if = branch_taken && !stall_id. A branch that depends on a load waits; branch_taken is ignored while stall_id=1.
- Load-use and structural hazard in the same cycle: pc_hold=1, stall_id=1, if_bubble=0.
- id_valid=0: no stall, all selects 0, ex_tag invalid next cycle.
- Reset: next edge sets all tags invalid, state IDLE, cnt=0. Reset is allowed mid-stall or mid-wait.
- Outputs during reset: pc_hold=0, stall_id=0, if_bubble=0, flush_if=0, all selects 0.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds output perf_stall_cnt [15:0]:
  - increments by 1 each cycle with pc_hold=1;
  - saturates at 0xFFFF;
  - cleared by rst.
- Adds output perf_lu_cnt [15:0]: counts LU_STALL entries, saturating, cleared by rst.
- When undefined, neither port exists and there is no counter logic.

Test Plan:
- addu r1 (dst 1) then addu reading r1 as rs, next cycle -> fwd_rs_sel=1, no stall, pc_hold=0.
- lw r2 then or reading rm=2 -> one cycle stall_id=1 and pc_hold=1; next cycle fwd_rm_sel=2; r2 result appears in EX 0x00A5 when the load returns 0x00A5.
- slt (dst 11) then bteqz (uses_t), next cycle -> fwd_t_sel=1. Same pair with a nop between them -> fwd_t_sel=2.
- MEM_WAIT_CYCLES=3, mem_ram_access pulse -> pc_hold high 3 cycles, if_bubble high 3 cycles, then IDLE.
- lw r3 followed by a branch reading r3 with branch_taken=1 -> flush_if=0 during the stall and 1 on the following cycle.
- rst asserted in the middle of SM_WAIT with cnt=2 -> next cycle state IDLE, pc_hold=0, all tags invalid, all selects 0.
